trail_stack: RTL and testbench

Assignment trail and backtrack engine for the DPLL core; the producing side of the decider's backtrack port. It records every variable assignment (decision or implied) in chronological order. On a conflict it pops implied and exhausted entries, emitting one unassignment per cycle, until it reaches the most recent untried decision. It then flips that decision in place and drives the decider's `write`/`back_dec_idx` pair. If no untried decision remains, it reports UNSAT.

---
 rtl/trail_stack_pkg.sv | 22 ++
 rtl/trail_mem.sv | 28 ++
 rtl/trail_stack.sv | 173 +++++++++++++++++
 tb/tb_trail_stack.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trail_stack_pkg.sv
// Shared types for the assignment trail: sizing constants, entry layout, FSM states.
package trail_stack_pkg;

  localparam int MAX_VARS      = 16;
  localparam int MAX_VARS_BITS = 4;

  // One trail entry. flipped marks a decision whose other branch is already taken.
  typedef struct packed {
    logic [MAX_VARS_BITS-1:0] var_idx;
    logic                     val;
    logic                     is_dec;
    logic                     flipped;
    logic [MAX_VARS_BITS-1:0] dec_idx;
  } trail_entry;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    UNSAT = 2'd2
  } bt_state_t;

endpackage

// File: rtl/trail_mem.sv
// Register-array stack storage: one write port (append or in-place flip) and a
// combinational read of the current top-of-stack entry.
module trail_mem
  import trail_stack_pkg::*;
#(
  parameter int DEPTH = MAX_VARS,
  parameter int IDX_W = MAX_VARS_BITS
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  trail_entry       i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output trail_entry       o_rdata
);

  trail_entry r_mem [DEPTH];

  // Entry storage carries no reset; only count decides which entries are live.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trail_stack.sv
// Assignment trail and backtrack engine: records assignments in order and, on a
// conflict, unwinds to the most recent untried decision and flips it.
module trail_stack
  import trail_stack_pkg::*;
#(
  parameter int DEPTH = MAX_VARS,
  parameter int IDX_W = MAX_VARS_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_var_idx,
  input  logic             push_val,
  input  logic             push_is_dec,
  input  logic [IDX_W-1:0] push_dec_idx,
  input  logic             conflict,
  output logic             busy,
  output logic             unassign_valid,
  output logic [IDX_W-1:0] unassign_var_idx,
  output logic             back_write,
  output logic [IDX_W-1:0] back_dec_idx,
  output logic             flip_valid,
  output logic [IDX_W-1:0] flip_var_idx,
  output logic             flip_val,
  output logic             unsat,
  output logic             overflow,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] L_DEPTH = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] L_ONE   = (IDX_W+1)'(1);

  bt_state_t        r_state, w_state_nxt;
  logic [IDX_W:0]   r_count;
  logic             r_busy, r_unassign_valid, r_back_write, r_flip_valid;
  logic             r_flip_val, r_unsat, r_overflow;
  logic [IDX_W-1:0] r_unassign_var_idx, r_back_dec_idx, r_flip_var_idx;

  trail_entry       w_top, w_wdata;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr, w_top_idx;
  logic             w_push_ok, w_push_ovf, w_pop, w_flip, w_to_unsat;

  // When count is 0 this index wraps, but the top entry is not consulted then.
  assign w_top_idx = IDX_W'(r_count - L_ONE);

  trail_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_top_idx),
    .o_rdata (w_top)
  );

  // Next-state and per-cycle action decode for IDLE/POP/UNSAT.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_count[IDX_W-1:0];
    w_wdata     = '{var_idx: push_var_idx, val: push_val, is_dec: push_is_dec,
                    flipped: 1'b0, dec_idx: push_dec_idx};
    w_push_ok   = 1'b0;
    w_push_ovf  = 1'b0;
    w_pop       = 1'b0;
    w_flip      = 1'b0;
    w_to_unsat  = 1'b0;
    case (r_state)
      IDLE: begin
        // A push in the same cycle as a conflict lands first, so it is unwound too.
        if (push) begin
          if (r_count < L_DEPTH) begin
            w_push_ok = 1'b1;
            w_we      = 1'b1;
          end else begin
            w_push_ovf = 1'b1;
          end
        end
        if (conflict) begin
          w_state_nxt = POP;
        end
      end
      POP: begin
        if (r_count == '0) begin
          w_to_unsat  = 1'b1;
          w_state_nxt = UNSAT;
        end else if (w_top.is_dec && !w_top.flipped) begin
          w_flip          = 1'b1;
          w_we            = 1'b1;
          w_waddr         = w_top_idx;
          w_wdata         = w_top;
          w_wdata.val     = ~w_top.val;
          w_wdata.flipped = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_pop = 1'b1;
        end
      end
      UNSAT: begin
        w_state_nxt = UNSAT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any backtrack in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered counter, pulses, sticky flags and their payloads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count            <= '0;
      r_busy             <= 1'b0;
      r_unassign_valid   <= 1'b0;
      r_unassign_var_idx <= '0;
      r_back_write       <= 1'b0;
      r_back_dec_idx     <= '0;
      r_flip_valid       <= 1'b0;
      r_flip_var_idx     <= '0;
      r_flip_val         <= 1'b0;
      r_unsat            <= 1'b0;
      r_overflow         <= 1'b0;
    end else begin
      r_busy           <= (w_state_nxt != IDLE);
      r_unassign_valid <= w_pop;
      r_back_write     <= w_flip;
      r_flip_valid     <= w_flip;
      if (w_push_ok) begin
        r_count <= r_count + L_ONE;
      end else if (w_pop) begin
        r_count <= r_count - L_ONE;
      end
      if (w_pop) begin
        r_unassign_var_idx <= w_top.var_idx;
      end
      if (w_flip) begin
        r_back_dec_idx <= w_top.dec_idx;
        r_flip_var_idx <= w_top.var_idx;
        r_flip_val     <= ~w_top.val;
      end
      if (w_push_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_to_unsat) begin
        r_unsat <= 1'b1;
      end
    end
  end

  assign busy             = r_busy;
  assign unassign_valid   = r_unassign_valid;
  assign unassign_var_idx = r_unassign_var_idx;
  assign back_write       = r_back_write;
  assign back_dec_idx     = r_back_dec_idx;
  assign flip_valid       = r_flip_valid;
  assign flip_var_idx     = r_flip_var_idx;
  assign flip_val         = r_flip_val;
  assign unsat            = r_unsat;
  assign overflow         = r_overflow;
  assign count            = r_count;

endmodule

// File: tb/tb_trail_stack.sv
// Randomized scoreboard bench for trail_stack with a queue-based reference model.
module tb_trail_stack;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0, push_val = 1'b0, push_is_dec = 1'b0, conflict = 1'b0;
  logic [IDX_W-1:0] push_var_idx = '0, push_dec_idx = '0;
  logic             busy, unassign_valid, back_write, flip_valid, flip_val, unsat, overflow;
  logic [IDX_W-1:0] unassign_var_idx, back_dec_idx, flip_var_idx;
  logic [IDX_W:0]   count;

  trail_stack #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .push             (push),
    .push_var_idx     (push_var_idx),
    .push_val         (push_val),
    .push_is_dec      (push_is_dec),
    .push_dec_idx     (push_dec_idx),
    .conflict         (conflict),
    .busy             (busy),
    .unassign_valid   (unassign_valid),
    .unassign_var_idx (unassign_var_idx),
    .back_write       (back_write),
    .back_dec_idx     (back_dec_idx),
    .flip_valid       (flip_valid),
    .flip_var_idx     (flip_var_idx),
    .flip_val         (flip_val),
    .unsat            (unsat),
    .overflow         (overflow),
    .count            (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [IDX_W-1:0] v;
    logic             val;
    logic             dec;
    logic             fl;
    logic [IDX_W-1:0] di;
  } ent_t;

  // kind: 0 = unassign, 1 = flip, 2 = unsat
  typedef struct {
    int               kind;
    logic [IDX_W-1:0] v;
    logic             val;
    logic [IDX_W-1:0] di;
  } ev_t;

  ent_t trail[$];
  ev_t  exp_q[$];
  bit   m_unsat, m_ovf;
  int   checks = 0;
  int   errors = 0;
  ev_t  mon_e;
  logic prev_unsat = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_push(logic [IDX_W-1:0] v, logic val, logic dec, logic [IDX_W-1:0] di);
    ent_t e;
    if (trail.size() < DEPTH) begin
      e.v = v; e.val = val; e.dec = dec; e.fl = 1'b0; e.di = di;
      trail.push_back(e);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_backtrack();
    ent_t e;
    ev_t  x;
    forever begin
      if (trail.size() == 0) begin
        x.kind = 2; x.v = '0; x.val = 1'b0; x.di = '0;
        exp_q.push_back(x);
        m_unsat = 1'b1;
        break;
      end
      e = trail[trail.size()-1];
      if (e.dec && !e.fl) begin
        e.val = !e.val;
        e.fl  = 1'b1;
        trail[trail.size()-1] = e;
        x.kind = 1; x.v = e.v; x.val = e.val; x.di = e.di;
        exp_q.push_back(x);
        break;
      end
      x.kind = 0; x.v = e.v; x.val = 1'b0; x.di = '0;
      exp_q.push_back(x);
      void'(trail.pop_back());
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (unassign_valid || back_write || flip_valid) begin
        chk("pulse_exclusive", 32'(unassign_valid && (back_write || flip_valid)), 32'd0);
      end
      if (unassign_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_unassign", 32'(unassign_var_idx), 32'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("unassign_kind", 32'(0), 32'(mon_e.kind));
          chk("unassign_var", 32'(unassign_var_idx), 32'(mon_e.v));
        end
      end
      if (back_write || flip_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flip", 32'(flip_var_idx), 32'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("flip_kind", 32'(1), 32'(mon_e.kind));
          chk("flip_pair", 32'({back_write, flip_valid}), 32'd3);
          chk("back_dec_idx", 32'(back_dec_idx), 32'(mon_e.di));
          chk("flip_var", 32'(flip_var_idx), 32'(mon_e.v));
          chk("flip_val", 32'(flip_val), 32'(mon_e.val));
        end
      end
      if (unsat && !prev_unsat) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_unsat", 32'(unsat), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("unsat_kind", 32'(2), 32'(mon_e.kind));
        end
      end
      prev_unsat = unsat;
    end else begin
      prev_unsat = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    push = 1'b0;
    conflict = 1'b0;
    exp_q.delete();
    trail.delete();
    m_unsat = 1'b0;
    m_ovf = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic set_push(logic [IDX_W-1:0] v, logic val, logic dec, logic [IDX_W-1:0] di);
    push = 1'b1; push_var_idx = v; push_val = val; push_is_dec = dec; push_dec_idx = di;
    if (!m_unsat) model_push(v, val, dec, di);
  endtask

  task automatic do_push(logic [IDX_W-1:0] v, logic val, logic dec, logic [IDX_W-1:0] di);
    set_push(v, val, dec, di);
    tick();
    push = 1'b0;
  endtask

  task automatic do_conflict(bit with_push, logic [IDX_W-1:0] v, logic val, logic dec,
                             logic [IDX_W-1:0] di);
    bit done;
    if (with_push) set_push(v, val, dec, di);
    conflict = 1'b1;
    if (!m_unsat) model_backtrack();
    tick();
    push = 1'b0;
    conflict = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3*DEPTH + 8; i++) begin
      if (m_unsat ? (unsat === 1'b1) : (busy === 1'b0)) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("bt_finished", 32'(done), 32'd1);
    tick();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    chk("count", 32'(count), 32'(trail.size()));
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_unassign_valid"}, 32'(unassign_valid), 32'd0);
    chk({tag, "_unassign_var"}, 32'(unassign_var_idx), 32'd0);
    chk({tag, "_back_write"}, 32'(back_write), 32'd0);
    chk({tag, "_back_dec_idx"}, 32'(back_dec_idx), 32'd0);
    chk({tag, "_flip_valid"}, 32'(flip_valid), 32'd0);
    chk({tag, "_flip_var"}, 32'(flip_var_idx), 32'd0);
    chk({tag, "_flip_val"}, 32'(flip_val), 32'd0);
    chk({tag, "_unsat"}, 32'(unsat), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset();
    check_all_zero("rst");

    // Implied 3, decision 5, implied 7, then conflict: pop 7, flip 5.
    do_push(4'd3, 1'b1, 1'b0, 4'd0);
    do_push(4'd5, 1'b0, 1'b1, 4'd0);
    do_push(4'd7, 1'b0, 1'b0, 4'd0);
    chk("t1_count_pre", 32'(count), 32'd3);
    do_conflict(1'b0, '0, 1'b0, 1'b0, '0);
    chk("t1_count", 32'(count), 32'd2);
    chk("t1_busy", 32'(busy), 32'd0);

    // Second conflict exhausts the trail.
    do_conflict(1'b0, '0, 1'b0, 1'b0, '0);
    chk("t2_unsat", 32'(unsat), 32'd1);
    do_push(4'd9, 1'b1, 1'b0, 4'd0);
    repeat (3) tick();
    chk("t2_busy_stuck", 32'(busy), 32'd1);
    chk("t2_count", 32'(count), 32'd0);

    // Two decisions: immediate flip of the newest.
    do_reset();
    do_push(4'd1, 1'b0, 1'b1, 4'd0);
    do_push(4'd2, 1'b1, 1'b1, 4'd1);
    do_conflict(1'b0, '0, 1'b0, 1'b0, '0);
    chk("t3_count", 32'(count), 32'd2);

    // Fill to capacity, then overflow; backtrack verifies stored contents.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_push(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)));
    end
    chk("t4_count_full", 32'(count), 32'(DEPTH));
    chk("t4_ovf_before", 32'(overflow), 32'd0);
    do_push(4'd15, 1'b1, 1'b1, 4'd15);
    chk("t4_count_after", 32'(count), 32'(DEPTH));
    chk("t4_ovf_after", 32'(overflow), 32'd1);
    do_conflict(1'b0, '0, 1'b0, 1'b0, '0);

    // Push coincident with conflict is unwound first.
    do_reset();
    do_push(4'd4, 1'b1, 1'b1, 4'd2);
    do_conflict(1'b1, 4'd6, 1'b0, 1'b0, 4'd0);
    do_conflict(1'b1, 4'd8, 1'b1, 1'b1, 4'd3);

    // Randomized mix of pushes and conflicts.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        do_push(4'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), 4'($urandom));
      end else if (r < 9) begin
        do_conflict(1'b0, '0, 1'b0, 1'b0, '0);
      end else begin
        do_conflict(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      end
      chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
      chk("rnd_unsat", 32'(unsat), 32'(m_unsat));
      chk("rnd_count", 32'(count), 32'(trail.size()));
      if (m_unsat) do_reset();
    end

    // Reset asserted mid-POP after two pops.
    do_reset();
    for (int i = 0; i < 4; i++) do_push(4'(10 + i), 1'b1, 1'b0, 4'd0);
    conflict = 1'b1;
    model_backtrack();
    tick();
    conflict = 1'b0;
    tick();
    tick();
    chk("t7_count_mid", 32'(count), 32'd2);
    do_reset();
    check_all_zero("t7");
    do_push(4'd1, 1'b1, 1'b0, 4'd0);
    chk("t7_count_push", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
